reg_select_sequencer: RTL and testbench
=======================================

Name: reg_select_sequencer

Overview:
- Upstream neighbour of the 4-to-16 register decoder in the datapath.
- Holds the instruction register (IR) and selects the Ra, Rb or Rc field as the 4-bit register index that feeds the decoder.
- Produces the sign-extended C constant.
- Contains a small FSM that auto-sequences register-file accesses for 3-operand ALU instructions, using a request/ack handshake with the control unit.

Parameters:
- DATA_W, 32, IR/constant width.
- C_W, 19, width of C field (IR[C_W-1:0]).

Ports:
- clock  in  1  rising-edge clock.
- clear_n  in  1  asynchronous active-low reset.
- ir_in  in  DATA_W  instruction word from bus.
- ir_load  in  1  load ir_in into IR this cycle.
- gra / grb / grc  in  1 each  manual field select (one-hot, used when FSM idle).
- r_in / r_out  in  1 each  manual write/read strobe.
- start  in  1  begin auto sequence (Rb read, Rc read, Ra write).
- ack  in  1  control unit accepted current step.
- sel_idx  out  4  register index to decoder.
- rin_en / rout_en  out  1 each  write/read enable accompanying sel_idx.
- busy  out  1  FSM not IDLE.
- done  out  1  one-cycle pulse at end of sequence.
- c_sext  out  DATA_W  IR[C_W-1:0] sign-extended from bit C_W-1.
- ir_q  out  DATA_W  current IR contents.

Behaviour:
- Reset (clear_n=0, async): IR=0, state=IDLE.
  - All outputs 0: sel_idx=0, rin_en=0, rout_en=0, busy=0, done=0, c_sext=0.
- IR fields: Ra=IR[26:23], Rb=IR[22:19], Rc=IR[18:15].
- IR load: on clock edge when ir_load=1, IR<=ir_in.
  - Ignored while busy=1; IR is held stable for the whole sequence.
- c_sext: combinational from IR; valid one cycle after the load edge.
- Manual mode (state IDLE): combinational outputs.
  - sel_idx = (gra?Ra:0)|(grb?Rb:0)|(grc?Rc:0); multiple selects OR together (undefined use, no check).
  - rin_en=r_in, rout_en=r_out.
- FSM states: IDLE, RD_B, RD_C, WR_A, FIN.
  - IDLE: start=1 -> RD_B. Manual inputs are ignored from the next cycle.
  - RD_B: sel_idx=Rb, rout_en=1. ack=1 -> RD_C.
  - RD_C: sel_idx=Rc, rout_en=1. ack=1 -> WR_A.
  - WR_A: sel_idx=Ra, rin_en=1. ack=1 -> FIN.
  - FIN: done=1 for one cycle, all enables 0 -> IDLE.
- Outputs in RD_B, RD_C and WR_A are registered (Moore) and hold until ack.
  - Without ack, the FSM stalls indefinitely in the current state.
- busy=1 in RD_B, RD_C, WR_A and FIN.
- start while busy is ignored; start in the FIN cycle is ignored.
- start and ir_load in the same IDLE cycle: IR loads, and the sequence uses the newly loaded fields.
  - Implementation: fields come from the next-state IR value at entry to RD_B.
- ack in IDLE or FIN: no effect.
- clear_n asserted mid-sequence: immediate return to IDLE with all outputs 0; no done pulse.
- Latency: start to done = 4 cycles minimum (ack held high).

Optional Feature:
- Macro SELECT_R0_GUARD_EN.
- Defined:
  - Extra output r0_guard (1 bit) = 1 whenever rin_en=1 and sel_idx=0.
  - In WR_A with Ra=0, rin_en is forced 0, r0_guard=1, and the FSM still advances on ack (write to R0 suppressed).
- Undefined: r0_guard port absent; writes to index 0 pass through unchanged.

Test Plan:
- Reset mid-sequence: start, ack once, assert clear_n=0 -> state IDLE, sel_idx=0, busy=0, no done pulse.
- Load and manual read:
  - Load ir_in=0x0A9B_8000 (Ra=5, Rb=3, Rc=7).
  - grb=1, r_out=1 -> sel_idx=3, rout_en=1.
  - Swap to grb=0, gra=1, r_in=1 -> sel_idx=5, rin_en=1.
- Auto sequence, ack tied high, same IR:
  - sel_idx goes 3 (rout_en), 7 (rout_en), 5 (rin_en).
  - done pulses on the 4th cycle after start; busy high 4 cycles.
- Stall: hold ack=0 for 5 cycles in RD_C -> sel_idx=7 and rout_en=1 stable throughout; ir_load during the stall leaves ir_q unchanged.
- Sign extension: IR[18:0]=0x40000 -> c_sext=0xFFFC_0000; IR[18:0]=0x3FFFF -> c_sext=0x0003_FFFF.
- With SELECT_R0_GUARD_EN defined, Ra=0, auto sequence: in WR_A rin_en=0, r0_guard=1, done still pulses.

Source files
------------

// File: rtl/reg_select_sequencer.sv
// Instruction register, Ra/Rb/Rc index select and C sign extension, plus a small FSM that
// sequences Rb read, Rc read, Ra write. Optional macro SELECT_R0_GUARD_EN suppresses writes to R0.
//
// state | meaning
// IDLE  | manual field select and strobes drive the decoder
// RD_B  | read Rb, wait for ack
// RD_C  | read Rc, wait for ack
// WR_A  | write Ra, wait for ack
// FIN   | one-cycle done pulse, enables off
module reg_select_sequencer #(
   parameter int DATA_W = 32,
   parameter int C_W    = 19
) (
   input  logic              clock,
   input  logic              clear_n,
   input  logic [DATA_W-1:0] ir_in,
   input  logic              ir_load,
   input  logic              gra,
   input  logic              grb,
   input  logic              grc,
   input  logic              r_in,
   input  logic              r_out,
   input  logic              start,
   input  logic              ack,
   output logic [3:0]        sel_idx,
   output logic              rin_en,
   output logic              rout_en,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] c_sext,
   output logic [DATA_W-1:0] ir_q
`ifdef SELECT_R0_GUARD_EN
   ,
   output logic              r0_guard
`endif
);

   typedef enum logic [2:0] {IDLE, RD_B, RD_C, WR_A, FIN} state_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] ir_d;
   logic [3:0]        sel_q, sel_d;
   logic              rin_q, rin_d;
   logic              rout_q, rout_d;
   logic              done_q, done_d;
   logic [3:0]        manual_sel;
   logic              rin_raw;
   logic              idle;

   assign idle = (state_q == IDLE);
   assign ir_d = (ir_load && idle) ? ir_in : ir_q;

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         state_q <= IDLE;
         ir_q    <= '0;
         sel_q   <= '0;
         rin_q   <= 1'b0;
         rout_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
         sel_q   <= sel_d;
         rin_q   <= rin_d;
         rout_q  <= rout_d;
         done_q  <= done_d;
      end
   end

   // Step outputs are decoded from the next state and next IR, so a start coinciding
   // with an IR load already uses the new fields in RD_B.
   always_comb begin
      state_d = state_q;
      sel_d   = 4'd0;
      rin_d   = 1'b0;
      rout_d  = 1'b0;
      done_d  = 1'b0;
      case (state_q)
         IDLE:    if (start) state_d = RD_B;
         RD_B:    if (ack)   state_d = RD_C;
         RD_C:    if (ack)   state_d = WR_A;
         WR_A:    if (ack)   state_d = FIN;
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
      case (state_d)
         RD_B: begin
            sel_d  = ir_d[22:19];
            rout_d = 1'b1;
         end
         RD_C: begin
            sel_d  = ir_d[18:15];
            rout_d = 1'b1;
         end
         WR_A: begin
            sel_d = ir_d[26:23];
            rin_d = 1'b1;
         end
         FIN:     done_d = 1'b1;
         default: ;
      endcase
   end

   assign manual_sel = ({4{gra}} & ir_q[26:23]) |
                       ({4{grb}} & ir_q[22:19]) |
                       ({4{grc}} & ir_q[18:15]);

   // Manual strobes are masked by clear_n so every output reads 0 while reset is held.
   assign sel_idx = idle ? manual_sel : sel_q;
   assign rin_raw = idle ? (r_in & clear_n) : rin_q;
   assign rout_en = idle ? (r_out & clear_n) : rout_q;
   assign busy    = !idle;
   assign done    = done_q;
   assign c_sext  = {{(DATA_W-C_W){ir_q[C_W-1]}}, ir_q[C_W-1:0]};

`ifdef SELECT_R0_GUARD_EN
   assign r0_guard = rin_raw && (sel_idx == 4'd0);
   assign rin_en   = rin_raw && !((state_q == WR_A) && (sel_idx == 4'd0));
`else
   assign rin_en   = rin_raw;
`endif

endmodule

// File: tb/tb_reg_select_sequencer.sv
// Scoreboard bench for reg_select_sequencer: expected step outputs are queued as stimulus
// is applied and compared as each cycle completes.
module tb_reg_select_sequencer;
   localparam int DATA_W = 32;

   logic              clock = 1'b0;
   logic              clear_n;
   logic [DATA_W-1:0] ir_in;
   logic              ir_load, gra, grb, grc, r_in, r_out, start, ack;
   logic [3:0]        sel_idx;
   logic              rin_en, rout_en, busy, done;
   logic [DATA_W-1:0] c_sext, ir_q;
`ifdef SELECT_R0_GUARD_EN
   logic              r0_guard;
`endif
   logic [7:0]        obs_w;
   logic [7:0]        exp_q[$];
   int                n_chk = 0;
   int                n_fail = 0;

   always #5 clock = ~clock;

   reg_select_sequencer #(.DATA_W(DATA_W), .C_W(19)) dut (
      .clock   (clock),
      .clear_n (clear_n),
      .ir_in   (ir_in),
      .ir_load (ir_load),
      .gra     (gra),
      .grb     (grb),
      .grc     (grc),
      .r_in    (r_in),
      .r_out   (r_out),
      .start   (start),
      .ack     (ack),
      .sel_idx (sel_idx),
      .rin_en  (rin_en),
      .rout_en (rout_en),
      .busy    (busy),
      .done    (done),
      .c_sext  (c_sext),
      .ir_q    (ir_q)
`ifdef SELECT_R0_GUARD_EN
      ,
      .r0_guard(r0_guard)
`endif
   );

   assign obs_w = {sel_idx, rin_en, rout_en, busy, done};

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic push(input logic [3:0] sel, input logic rin, input logic rout,
                       input logic bsy, input logic dn);
      exp_q.push_back({sel, rin, rout, bsy, dn});
   endtask

   task automatic sb_cmp(input string tag);
      logic nonempty;
      nonempty = (exp_q.size() != 0);
      chk({tag, "_depth"}, 64'(nonempty), 64'd1);
      if (nonempty) chk(tag, 64'(obs_w), 64'(exp_q.pop_front()));
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      clear_n = 1'b0;
      ir_in = '0; ir_load = 0; gra = 0; grb = 0; grc = 0;
      r_in = 0; r_out = 0; start = 0; ack = 0;
      #2;
      push(4'd0, 0, 0, 0, 0);
      sb_cmp("reset");
      chk("reset_csext", c_sext, 0);
      chk("reset_ir", ir_q, 0);
      @(negedge clock);
      clear_n = 1'b1;
      tick();

      // load and manual select
      ir_in = 32'h0A9B_8000; ir_load = 1;
      tick();
      ir_load = 0;
      chk("ir_load", ir_q, 32'h0A9B_8000);
      chk("csext_pos_small", c_sext, 32'h0003_8000);
      grb = 1; r_out = 1; #1;
      push(4'd3, 0, 1, 0, 0); sb_cmp("man_rd_b");
      grb = 0; r_out = 0; gra = 1; r_in = 1; #1;
      push(4'd5, 1, 0, 0, 0); sb_cmp("man_wr_a");
      gra = 0; r_in = 0;

      // auto sequence, ack high, manual inputs asserted but ignored once busy
      start = 1; ack = 1;
      push(4'd3, 0, 1, 1, 0);
      push(4'd7, 0, 1, 1, 0);
      push(4'd5, 1, 0, 1, 0);
      push(4'd0, 0, 0, 1, 1);
      push(4'd0, 0, 0, 0, 0);
      tick(); start = 0; grc = 1; r_out = 1;
      sb_cmp("auto_rd_b");
      tick(); sb_cmp("auto_rd_c");
      tick(); sb_cmp("auto_wr_a");
      tick(); sb_cmp("auto_fin");
      grc = 0; r_out = 0;
      tick(); sb_cmp("auto_idle");

      // stall in RD_C with ir_load and start attempts
      ack = 0; start = 1;
      push(4'd3, 0, 1, 1, 0);
      tick(); start = 0; sb_cmp("stall_rd_b");
      ack = 1;
      push(4'd7, 0, 1, 1, 0);
      tick(); ack = 0; sb_cmp("stall_rd_c_entry");
      ir_in = 32'hFFFF_FFFF; ir_load = 1; start = 1;
      for (int i = 0; i < 5; i++) begin
         push(4'd7, 0, 1, 1, 0);
         tick(); sb_cmp("stall_rd_c_hold");
         chk("stall_ir_hold", ir_q, 32'h0A9B_8000);
      end
      ir_load = 0; start = 0; ack = 1;
      push(4'd5, 1, 0, 1, 0);
      tick(); sb_cmp("stall_wr_a");
      push(4'd0, 0, 0, 1, 1);
      tick(); sb_cmp("stall_fin");
      start = 1;
      push(4'd0, 0, 0, 0, 0);
      tick(); start = 0; sb_cmp("fin_start_ignored");
      push(4'd0, 0, 0, 0, 0);
      tick(); sb_cmp("idle_after_fin");

      // start and ir_load in the same cycle use the new fields (Ra=1, Rb=2, Rc=4)
      ir_in = 32'h0092_0000; ir_load = 1; start = 1;
      push(4'd2, 0, 1, 1, 0);
      push(4'd4, 0, 1, 1, 0);
      push(4'd1, 1, 0, 1, 0);
      push(4'd0, 0, 0, 1, 1);
      tick(); ir_load = 0; start = 0;
      sb_cmp("ld_start_rd_b");
      chk("ld_start_ir", ir_q, 32'h0092_0000);
      tick(); sb_cmp("ld_start_rd_c");
      tick(); sb_cmp("ld_start_wr_a");
      tick(); sb_cmp("ld_start_fin");

      // ir_load during FIN is ignored, then sign extension of the C field
      ir_in = 32'h0004_0000; ir_load = 1;
      tick();
      chk("fin_load_ignored", ir_q, 32'h0092_0000);
      tick();
      chk("csext_neg", c_sext, 32'hFFFC_0000);
      ir_in = 32'h0003_FFFF;
      tick();
      chk("csext_pos_max", c_sext, 32'h0003_FFFF);
      ir_load = 0;

      // Ra=0 sequence (Rb=6, Rc=9)
      ir_in = 32'h0034_8000; ir_load = 1; start = 1; ack = 1;
      push(4'd6, 0, 1, 1, 0);
      push(4'd9, 0, 1, 1, 0);
`ifdef SELECT_R0_GUARD_EN
      push(4'd0, 0, 0, 1, 0);
`else
      push(4'd0, 1, 0, 1, 0);
`endif
      push(4'd0, 0, 0, 1, 1);
      push(4'd0, 0, 0, 0, 0);
      tick(); ir_load = 0; start = 0;
      sb_cmp("r0_rd_b");
      tick(); sb_cmp("r0_rd_c");
      tick(); sb_cmp("r0_wr_a");
`ifdef SELECT_R0_GUARD_EN
      chk("r0_guard_flag", 64'(r0_guard), 64'd1);
`endif
      tick(); sb_cmp("r0_fin");
      tick(); sb_cmp("r0_idle");

      // reset in the middle of a sequence
      start = 1; ack = 1;
      push(4'd6, 0, 1, 1, 0);
      push(4'd9, 0, 1, 1, 0);
      tick(); start = 0; sb_cmp("mid_rd_b");
      tick(); ack = 0; sb_cmp("mid_rd_c");
      clear_n = 1'b0;
      #1;
      push(4'd0, 0, 0, 0, 0); sb_cmp("mid_reset");
      chk("mid_reset_ir", ir_q, 0);
      push(4'd0, 0, 0, 0, 0);
      tick(); sb_cmp("mid_reset_hold");
      @(negedge clock);
      clear_n = 1'b1;
      ack = 1;
      push(4'd0, 0, 0, 0, 0);
      tick(); sb_cmp("post_reset_no_done");
      push(4'd0, 0, 0, 0, 0);
      tick(); sb_cmp("post_reset_idle");

      chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
